// File: rtl/fixed_act_arb_pkg.sv
// Shared types and helpers for the fixed activation arbiter.
package fixed_act_arb_pkg;

    localparam int PERF_CNT_W = 32;
    localparam int MAX_REQ    = 16;

    // Round-robin pick: first set bit of valid at or above ptr, wrapping at n.
    function automatic int unsigned rr_pick(input logic [MAX_REQ-1:0] valid,
                                            input int unsigned ptr,
                                            input int unsigned n);
        int unsigned idx;
        logic        found;
        rr_pick = ptr;
        found   = 1'b0;
        for (int unsigned i = 0; i < MAX_REQ; i++) begin
            if (i < n) begin
                idx = ptr + i;
                if (idx >= n) idx = idx - n;
                if (!found && valid[idx[3:0]]) begin
                    rr_pick = idx;
                    found   = 1'b1;
                end
            end
        end
    endfunction

    function automatic logic [MAX_REQ-1:0] onehot(input int unsigned id);
        onehot = '0;
        onehot[id[3:0]] = 1'b1;
    endfunction

endpackage

// File: rtl/fixed_act_tag_fifo.sv
// Requester-id FIFO: one entry per beat currently inside the activation unit.
module fixed_act_tag_fifo
    import fixed_act_arb_pkg::*;
#(
    parameter int TAG_W = 2,
    parameter int DEPTH = 4,
    localparam int PTR_W = $clog2(DEPTH)
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             push,
    input  logic [TAG_W-1:0] push_tag,
    input  logic             pop,
    output logic [TAG_W-1:0] head_tag,
    output logic             full,
    output logic             empty,
    output logic [PTR_W:0]   count
);

    logic [TAG_W-1:0] mem [DEPTH];
    logic [PTR_W-1:0] wr_ptr;
    logic [PTR_W-1:0] rd_ptr;
    logic             do_push;
    logic             do_pop;

    assign full     = (count == (PTR_W+1)'(DEPTH));
    assign empty    = (count == '0);
    assign do_push  = push && !full;
    assign do_pop   = pop && !empty;
    assign head_tag = mem[rd_ptr];

    // Tag storage; contents are don't-care while empty, so no reset.
    always_ff @(posedge clk) begin
        if (do_push) mem[wr_ptr] <= push_tag;
    end

    // Pointers and occupancy; simultaneous push/pop leaves count unchanged.
    always_ff @(posedge clk) begin
        if (!rst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (do_push) wr_ptr <= wr_ptr + 1'b1;
            if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
            case ({do_push, do_pop})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: count <= count;
            endcase
        end
    end

endmodule

// File: rtl/fixed_activation_arbiter.sv
// Round-robin sharing of one in-order activation unit among NUM_REQ requesters.
// Each issued beat's requester id is queued so results route back in order.
// Optional macro FIXED_ACT_ARB_PERF_EN adds grant/stall performance counters.
module fixed_activation_arbiter
    import fixed_act_arb_pkg::*;
#(
    parameter int NUM_REQ                = 4,
    parameter int DATA_IN_0_PRECISION_0  = 16,
    parameter int DATA_OUT_0_PRECISION_0 = 32,
    parameter int MAX_OUTSTANDING        = 4,
    localparam int TAG_W = $clog2(NUM_REQ),
    localparam int CNT_W = $clog2(MAX_OUTSTANDING) + 1
) (
    input  logic                                      clk,
    input  logic                                      rst,
    input  logic [NUM_REQ*DATA_IN_0_PRECISION_0-1:0]  req_data,
    input  logic [NUM_REQ-1:0]                        req_valid,
    output logic [NUM_REQ-1:0]                        req_ready,
    output logic [DATA_IN_0_PRECISION_0-1:0]          act_in_data,
    output logic                                      act_in_valid,
    input  logic                                      act_in_ready,
    input  logic [DATA_OUT_0_PRECISION_0-1:0]         act_out_data,
    input  logic                                      act_out_valid,
    output logic                                      act_out_ready,
    output logic [DATA_OUT_0_PRECISION_0-1:0]         rsp_data,
    output logic [NUM_REQ-1:0]                        rsp_valid,
    input  logic [NUM_REQ-1:0]                        rsp_ready,
    output logic [CNT_W-1:0]                          outstanding,
    output logic                                      err_orphan
`ifdef FIXED_ACT_ARB_PERF_EN
    ,
    output logic [NUM_REQ*PERF_CNT_W-1:0]             perf_grant_cnt,
    output logic [PERF_CNT_W-1:0]                     perf_stall_cnt
`endif
);

    localparam int DW = DATA_IN_0_PRECISION_0;

    logic [TAG_W-1:0] rr_ptr;
    logic [TAG_W-1:0] grant;
    logic [TAG_W-1:0] head_tag;
    logic             any_valid;
    logic             full;
    logic             empty;
    logic             issue_ok;
    logic             push;
    logic             pop;

    assign any_valid = |req_valid;

    // Issue is held off while in reset so nothing leaks into the unit that
    // is being reset alongside us.
    assign issue_ok = rst && any_valid && !full;

    // Combinational round-robin grant and issue-side handshake signals.
    always_comb begin
        grant        = TAG_W'(rr_pick(MAX_REQ'(req_valid), 32'(rr_ptr), NUM_REQ));
        act_in_valid = issue_ok;
        act_in_data  = req_data[int'(grant)*DW +: DW];
        req_ready    = '0;
        req_ready[grant] = issue_ok && act_in_ready;
    end

    assign push = act_in_valid && act_in_ready;

    // Return-side routing: head tag selects which requester sees the result.
    always_comb begin
        rsp_data      = act_out_data;
        rsp_valid     = '0;
        act_out_ready = 1'b0;
        if (rst && !empty) begin
            if (act_out_valid) rsp_valid = NUM_REQ'(onehot(32'(head_tag)));
            act_out_ready = rsp_ready[head_tag];
        end
    end

    assign pop = act_out_valid && act_out_ready;

    fixed_act_tag_fifo #(
        .TAG_W (TAG_W),
        .DEPTH (MAX_OUTSTANDING)
    ) u_tag_fifo (
        .clk      (clk),
        .rst      (rst),
        .push     (push),
        .push_tag (grant),
        .pop      (pop),
        .head_tag (head_tag),
        .full     (full),
        .empty    (empty),
        .count    (outstanding)
    );

    // Round-robin pointer advances past the winner only on a real issue.
    always_ff @(posedge clk) begin
        if (!rst) begin
            rr_ptr <= '0;
        end else if (push) begin
            rr_ptr <= (grant == TAG_W'(NUM_REQ-1)) ? '0 : grant + 1'b1;
        end
    end

    // Sticky flag for a result arriving with no tag to route it to.
    always_ff @(posedge clk) begin
        if (!rst) begin
            err_orphan <= 1'b0;
        end else if (act_out_valid && empty) begin
            err_orphan <= 1'b1;
        end
    end

`ifdef FIXED_ACT_ARB_PERF_EN
    // Saturating per-requester grant counters and full-stall counter.
    always_ff @(posedge clk) begin
        if (!rst) begin
            perf_grant_cnt <= '0;
            perf_stall_cnt <= '0;
        end else begin
            for (int k = 0; k < NUM_REQ; k++) begin
                if (push && grant == TAG_W'(k) &&
                    perf_grant_cnt[k*PERF_CNT_W +: PERF_CNT_W] != '1) begin
                    perf_grant_cnt[k*PERF_CNT_W +: PERF_CNT_W] <=
                        perf_grant_cnt[k*PERF_CNT_W +: PERF_CNT_W] + 1'b1;
                end
            end
            if (any_valid && full && perf_stall_cnt != '1) begin
                perf_stall_cnt <= perf_stall_cnt + 1'b1;
            end
        end
    end
`endif

endmodule
